// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with registered reads, write-first
// bypass, synchronous bulk clear and an out-of-range access error pulse.
module regfile_2r1w #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 8,
    parameter int unsigned      ADDR_W    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    output logic              rvalid0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid1,
    output logic              err
);

    localparam bit FULL = (DEPTH == (1 << ADDR_W));

    logic [WIDTH-1:0] mem [DEPTH];
    logic             oob_w, oob_r0, oob_r1;
    logic [WIDTH-1:0] rnext0, rnext1;
    logic             err_next;

    // A fully populated address space has no out-of-range addresses at all.
    generate
        if (FULL) begin : g_full
            assign oob_w  = 1'b0;
            assign oob_r0 = 1'b0;
            assign oob_r1 = 1'b0;
        end else begin : g_partial
            localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
            assign oob_w  = ({1'b0, waddr}  >= LIMIT);
            assign oob_r0 = ({1'b0, raddr0} >= LIMIT);
            assign oob_r1 = ({1'b0, raddr1} >= LIMIT);
        end
    endgenerate

    function automatic logic [WIDTH-1:0] entry(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) v = mem[i];
        end
        return v;
    endfunction

    // Priority: clear, out-of-range, write bypass, stored entry.
    always_comb begin
        rnext0   = entry(raddr0);
        rnext1   = entry(raddr1);
        if (we && waddr == raddr0) rnext0 = wdata;
        if (we && waddr == raddr1) rnext1 = wdata;
        if (oob_r0) rnext0 = '0;
        if (oob_r1) rnext1 = '0;
        if (clr) begin
            rnext0 = RESET_VAL;
            rnext1 = RESET_VAL;
        end
        err_next = (we && !clr && oob_w) || (re0 && oob_r0) || (re1 && oob_r1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else if (we && !oob_w) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (waddr == ADDR_W'(i)) mem[i] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid0 <= re0;
            rvalid1 <= re1;
            err     <= err_next;
            if (re0) rdata0 <= rnext0;
            if (re1) rdata1 <= rnext1;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomised bench for regfile_2r1w: a full-depth and a DEPTH=6 instance share
// stimulus and are both checked every cycle against an array-based model.
module tb_regfile_2r1w;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0, we = 1'b0, re0 = 1'b0, re1 = 1'b0;
    logic [2:0] waddr = '0, raddr0 = '0, raddr1 = '0;
    logic [7:0] wdata = '0;

    logic [7:0] rd0 [2];
    logic [7:0] rd1 [2];
    logic       rv0 [2];
    logic       rv1 [2];
    logic       er  [2];

    int unsigned dep [2] = '{8, 6};
    logic [7:0]  rv  [2] = '{8'h00, 8'h5A};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .RESET_VAL(8'h00)) dut_full (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .raddr0(raddr0), .rdata0(rd0[0]), .rvalid0(rv0[0]),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1[0]), .rvalid1(rv1[0]), .err(er[0])
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .RESET_VAL(8'h5A)) dut_part (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re0(re0), .raddr0(raddr0), .rdata0(rd0[1]), .rvalid0(rv0[1]),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1[1]), .rvalid1(rv1[1]), .err(er[1])
    );

    // Reference model: plain storage arrays plus the read priority rules.
    logic [7:0] mm [2][8];
    logic [7:0] md0 [2];
    logic [7:0] md1 [2];
    logic       mv0 [2];
    logic       mv1 [2];
    logic       me  [2];

    function automatic logic [7:0] rdexp(input int k, input logic [2:0] a);
        if (clr) return rv[k];
        if (int'(a) >= int'(dep[k])) return 8'h00;
        if (we && waddr == a) return wdata;
        return mm[k][a];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) mm[k][i] = rv[k];
                md0[k] = 8'h00; md1[k] = 8'h00;
                mv0[k] = 1'b0;  mv1[k] = 1'b0;  me[k] = 1'b0;
            end else begin
                mv0[k] = re0;
                mv1[k] = re1;
                if (re0) md0[k] = rdexp(k, raddr0);
                if (re1) md1[k] = rdexp(k, raddr1);
                me[k] = (we && !clr && int'(waddr) >= int'(dep[k]))
                     || (re0 && int'(raddr0) >= int'(dep[k]))
                     || (re1 && int'(raddr1) >= int'(dep[k]));
                if (clr) begin
                    for (int i = 0; i < 8; i++) mm[k][i] = rv[k];
                end else if (we && int'(waddr) < int'(dep[k])) begin
                    mm[k][waddr] = wdata;
                end
            end
        end
    end

    task automatic cmp(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cmp("rdata0", k, rd0[k], md0[k]);
            cmp("rdata1", k, rd1[k], md1[k]);
            cmp("rvalid0", k, {7'd0, rv0[k]}, {7'd0, mv0[k]});
            cmp("rvalid1", k, {7'd0, rv1[k]}, {7'd0, mv1[k]});
            cmp("err", k, {7'd0, er[k]}, {7'd0, me[k]});
        end
    end

    task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic r0, input logic [2:0] a0,
                         input logic r1, input logic [2:0] a1, input logic c);
        we = w; waddr = wa; wdata = wd;
        re0 = r0; raddr0 = a0; re1 = r1; raddr1 = a1; clr = c;
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        // T1: reset state, then read addresses 0 and 7 on both ports
        step; step;
        cmp("lit_rst_rdata0", 0, rd0[0], 8'h00);
        cmp("lit_rst_rvalid0", 0, {7'd0, rv0[0]}, 8'h00);
        cmp("lit_rst_err", 1, {7'd0, er[1]}, 8'h00);
        rst = 1'b0;
        drive(0, 0, 0, 1, 3'd0, 1, 3'd7, 0);
        step;
        cmp("lit_t1_rdata0", 0, rd0[0], 8'h00);
        cmp("lit_t1_rvalid1", 0, {7'd0, rv1[0]}, 8'h01);
        cmp("lit_t1_rdata0_rv", 1, rd0[1], 8'h5A);
        cmp("lit_t1_err_oob", 1, {7'd0, er[1]}, 8'h01);
        cmp("lit_t1_err_full", 0, {7'd0, er[0]}, 8'h00);

        // T2: write then read, then hold
        drive(1, 3'd3, 8'hA5, 0, 0, 0, 0, 0); step;
        drive(0, 0, 0, 1, 3'd3, 0, 0, 0);     step;
        cmp("lit_t2_rdata0", 0, rd0[0], 8'hA5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);        step;
        cmp("lit_t2_hold", 0, rd0[0], 8'hA5);
        cmp("lit_t2_rvalid0", 0, {7'd0, rv0[0]}, 8'h00);

        // T3: same-cycle bypass on both ports
        drive(1, 3'd5, 8'h3C, 1, 3'd5, 1, 3'd5, 0); step;
        cmp("lit_t3_rdata0", 0, rd0[0], 8'h3C);
        cmp("lit_t3_rdata1", 1, rd1[1], 8'h3C);

        // T4: fill, then clear beats a simultaneous write
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 8'((i + 1) * 8'h11), 0, 0, 0, 0, 0); step;
        end
        drive(0, 0, 0, 1, 3'd7, 0, 0, 0); step;
        cmp("lit_t4_fill7", 0, rd0[0], 8'h88);
        drive(1, 3'd2, 8'hFF, 1, 3'd2, 0, 0, 1); step;
        cmp("lit_t4_clr_rd", 0, rd0[0], 8'h00);
        cmp("lit_t4_clr_rv", 1, rd0[1], 8'h5A);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 3'(i), 0, 0, 0); step;
            cmp("lit_t4_readback", 0, rd0[0], 8'h00);
        end

        // T5: out-of-range write and read on the DEPTH=6 instance
        drive(1, 3'd7, 8'h55, 0, 0, 1, 3'd6, 0); step;
        cmp("lit_t5_err", 1, {7'd0, er[1]}, 8'h01);
        cmp("lit_t5_rdata1", 1, rd1[1], 8'h00);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step;
        cmp("lit_t5_err_pulse", 1, {7'd0, er[1]}, 8'h00);

        // T6: asynchronous reset while a read is pending
        drive(1, 3'd4, 8'h44, 0, 0, 0, 0, 0); step;
        drive(0, 0, 0, 1, 3'd4, 0, 0, 0);
        #2 rst = 1'b1;
        step;
        cmp("lit_t6_rvalid0", 0, {7'd0, rv0[0]}, 8'h00);
        cmp("lit_t6_rdata0", 0, rd0[0], 8'h00);
        #1 rst = 1'b0;
        drive(0, 0, 0, 1, 3'd4, 0, 0, 0); step;
        cmp("lit_t6_entry4", 0, rd0[0], 8'h00);
        cmp("lit_t6_entry4_rv", 1, rd0[1], 8'h5A);

        // Randomised traffic with occasional clear and asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if (rst) #1 rst = 1'b0;
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 31) == 0));
            if ($urandom_range(0, 149) == 0) #2 rst = 1'b1;
            step;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
